// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and default parameters.
`ifndef FIFO_BURST_READER_PKG_SV
`define FIFO_BURST_READER_PKG_SV
package fifo_burst_reader_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_LENGTH_WIDTH   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_PAD_VALUE      = 0;
  localparam int UNDERRUN_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Counter width able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`endif

// File: rtl/fifo_burst_reader_timeout_counter.sv
// Consecutive-empty cycle counter; expired stays high once LIMIT is reached
// until cleared.
module timeout_counter
  import fifo_burst_reader_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise count enabled cycles and saturate at LIMIT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_V);

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from a show-ahead FIFO into a single output
// register; a burst starved for TIMEOUT_CYCLES is closed with a pad word.
// Handshake: a word transfers on a clock edge where out_valid && out_ready;
// out_valid never drops and the word never changes until that transfer.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LENGTH_WIDTH   = DEF_LENGTH_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = DATA_WIDTH'(DEF_PAD_VALUE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_read_enable,
  input  logic [LENGTH_WIDTH-1:0] burst_length,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    out_pad,
  output logic                    busy,
  output logic [15:0]             underrun_count
);

  state_e                  state_q;
  logic [LENGTH_WIDTH-1:0] len_q;
  logic [LENGTH_WIDTH-1:0] word_count_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    out_first_q;
  logic                    out_last_q;
  logic                    out_pad_q;
  logic [UNDERRUN_WIDTH-1:0] underrun_q;

  logic pop;
  logic accept;
  logic out_free;
  logic last_pop;
  logic timed_out;

  assign accept   = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;
  assign pop      = (state_q == READ) && !fifo_empty && out_free;
  assign last_pop = (word_count_q == (len_q - 1'b1));

  // Counts consecutive empty cycles while reading; any pop or leaving READ restarts it.
  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  ((state_q == READ) && fifo_empty),
    .clear   (pop || (state_q != READ)),
    .expired (timed_out)
  );

  // Burst FSM together with the output register and underrun counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_pad_q    <= 1'b0;
      underrun_q   <= '0;
    end else begin
      // Accepted word leaves; a load in the same cycle below overrides this.
      if (accept) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            len_q        <= (burst_length == '0) ? LENGTH_WIDTH'(1) : burst_length;
            word_count_q <= '0;
            state_q      <= READ;
          end
        end
        READ: begin
          if (pop) begin
            out_data_q   <= fifo_data;
            out_valid_q  <= 1'b1;
            out_first_q  <= (word_count_q == '0);
            out_last_q   <= last_pop;
            out_pad_q    <= 1'b0;
            word_count_q <= word_count_q + 1'b1;
            if (last_pop) begin
              state_q <= DRAIN;
            end
          end else if (timed_out) begin
            // A starved burst that never produced a word is simply abandoned.
            state_q <= (word_count_q != '0) ? PAD : IDLE;
          end
        end
        PAD: begin
          if (out_free) begin
            out_data_q  <= PAD_VALUE;
            out_valid_q <= 1'b1;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b1;
            out_pad_q   <= 1'b1;
            if (underrun_q != {UNDERRUN_WIDTH{1'b1}}) begin
              underrun_q <= underrun_q + 1'b1;
            end
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_free) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_read_enable = pop;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_first        = out_first_q;
  assign out_last         = out_last_q;
  assign out_pad          = out_pad_q;
  assign busy             = (state_q != IDLE);
  assign underrun_count   = underrun_q;

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_WIDTH, 8, word width.
- LENGTH_WIDTH, 4, width of burst_length.
- TIMEOUT_CYCLES, 16, consecutive empty cycles that abort a burst.
- PAD_VALUE, 0, data value of a pad word.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clock, in, 1, single clock; all logic on posedge.
- reset, in, 1, asynchronous, active-high.
- fifo_data, in, DATA_WIDTH, show-ahead FIFO head word; valid while fifo_empty=0.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_read_enable, out, 1, pops one word at the clock edge.
- burst_length, in, LENGTH_WIDTH, words per burst; sampled at burst start.
- out_data, out, DATA_WIDTH, downstream word.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts on out_valid&&out_ready.
- out_first, out, 1, word is first of its burst.
- out_last, out, 1, word is last of its burst.
- out_pad, out, 1, word is a timeout pad, not FIFO data.
- busy, out, 1, state not IDLE.
- underrun_count, out, 16, count of aborted bursts.

Function
REQ-003 FSM states SHALL be IDLE, READ, PAD, DRAIN.
REQ-004 The output stage SHALL be a single register: out_data, out_valid, out_first, out_last, out_pad.
REQ-005 In IDLE with fifo_empty=0, the block SHALL:
- latch burst_length, with 0 treated as 1;
- clear word_count and the timeout counter;
- go to READ at the next edge.
REQ-006 fifo_read_enable SHALL equal (state==READ) && !fifo_empty && (!out_valid || out_ready), combinationally.
REQ-007 On each pop the block SHALL:
- load out_data from fifo_data and set out_valid=1;
- set out_first=(word_count==0) and out_last=(word_count==latched_length-1);
- set out_pad=0;
- increment word_count.
REQ-008 A pop with out_last=1 SHALL move READ to DRAIN.
REQ-009 When out_valid&&out_ready and no new load occurs in the same cycle, out_valid SHALL clear. A simultaneous accept and pop SHALL sustain one word per cycle with no bubble.
REQ-010 Latency SHALL be one cycle from the cycle fifo_empty falls in IDLE to fifo_read_enable=1, and out_valid SHALL rise the cycle after the pop.
REQ-011 In READ, the timeout counter SHALL:
- increment on each cycle with fifo_empty=1;
- clear on each pop.
REQ-012 When the timeout counter reaches TIMEOUT_CYCLES while word_count>0, the block SHALL go to PAD. When word_count==0 it SHALL return to IDLE without emitting a word.
REQ-013 PAD SHALL load one pad word (out_data=PAD_VALUE, out_pad=1, out_last=1, out_first=0) when !out_valid||out_ready, increment underrun_count by 1, and go to DRAIN. fifo_read_enable SHALL be 0 in PAD.
REQ-014 DRAIN SHALL go to IDLE on the cycle the last word is accepted. fifo_read_enable SHALL be 0 in DRAIN.
REQ-015 While out_valid=1 and out_ready=0, out_data, out_first, out_last and out_pad SHALL hold stable.
REQ-016 underrun_count SHALL saturate at 16'hFFFF.
REQ-017 A burst of length 1 SHALL emit one word with out_first=1 and out_last=1.
REQ-018 busy SHALL be 1 in READ, PAD and DRAIN.

Reset
REQ-019 On reset assertion, asynchronously, the block SHALL set state=IDLE, all outputs and underrun_count=0, and fifo_read_enable=0 combinationally.
REQ-020 On reset asserted mid-burst, the block SHALL discard the partial burst with no further pops and no pad word.
REQ-021 After reset deassertion, the first burst SHALL begin per REQ-005.

Structure
REQ-022 The FSM state encodings and the default parameter values SHALL live in the shared fifo library include file, guarded by an ifndef.
REQ-023 The consecutive-empty timeout counter SHALL be a sub-module named timeout_counter, with ports clock, reset, enable, clear and expired.
REQ-024 This block SHALL connect directly to the fifo_single_clock read port with no added logic.

Verification
REQ-025 The bench SHALL cover these directed scenarios, each as stimulus -> required response, with out_ready=1 unless stated:
- Burst length 4, FIFO preloaded 0x01..0x04 -> four consecutive out_valid cycles; first on 0x01, last on 0x04; busy returns to 0.
- Burst length 4, FIFO preloaded 0x01..0x08 -> two bursts of four; out_first on 0x01 and 0x05; out_last on 0x04 and 0x08.
- Burst length 4, out_ready toggling 1,0,1,0 -> no pop while the output is held and unaccepted; data stable while stalled; order preserved.
- Burst length 4, only 0x11 and 0x22 written -> 16 empty cycles, then a pad word 0x00 with out_pad=1 and out_last=1; underrun_count=1.
- Burst length 0, FIFO holds 0xA5 -> single word with out_first=1 and out_last=1.
- Reset asserted after the second pop of a length-8 burst -> outputs 0 immediately; after release a fresh burst starts with out_first=1 on the next FIFO word.
